// File: rtl/bcd_pkg.sv
// Shared types and constants for the digit-serial BCD add/subtract controller.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_ADJ = 4'd6;

  function automatic logic digit_ok(input logic [3:0] d);
    return (d <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Single-digit BCD adder: x + y + ci with decimal adjust, shared across all digits.
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [4:0] sum_s;

  // Binary sum followed by decimal correction when the digit overflows 9.
  always_comb begin
    sum_s = {1'b0, x} + {1'b0, y} + {4'b0000, ci};
    if (sum_s > {1'b0, BCD_MAX}) begin
      s  = sum_s[3:0] + BCD_ADJ;
      co = 1'b1;
    end else begin
      s  = sum_s[3:0];
      co = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_serial_alu.sv
// Digit-serial BCD add/subtract controller: one digit per clock, LSD first,
// start/done handshake, operand validation and result assembly.
module bcd_serial_alu
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  op,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   result,
  output logic                  cout,
  output logic                  err
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_t          state_r, next_state_s;
  logic [W-1:0]    a_r, b_r, result_r;
  logic [CW-1:0]   cnt_r;
  logic            op_r, carry_r, cout_r, err_r, busy_r, done_r;
  logic            valid_s, last_s, co_s;
  logic [3:0]      y_s, digit_s;

  // Operand validation of the raw inputs, used only on the accepting cycle.
  always_comb begin
    valid_s = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      valid_s = valid_s & digit_ok(a[4*i +: 4]) & digit_ok(b[4*i +: 4]);
    end
  end

  // Subtraction uses nine's complement of b plus an initial carry of one.
  always_comb begin
    y_s    = op_r ? (BCD_MAX - b_r[3:0]) : b_r[3:0];
    last_s = (cnt_r == CW'(DIGITS - 1));
  end

  bcd_digit_add u_digit_add (
    .x  (a_r[3:0]),
    .y  (y_s),
    .ci (carry_r),
    .s  (digit_s),
    .co (co_s)
  );

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          next_state_s = valid_s ? RUN : DONE;
        end else begin
          next_state_s = IDLE;
        end
      end
      RUN:     next_state_s = last_s ? DONE : RUN;
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // State, datapath registers and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      a_r      <= '0;
      b_r      <= '0;
      result_r <= '0;
      cnt_r    <= '0;
      op_r     <= 1'b0;
      carry_r  <= 1'b0;
      cout_r   <= 1'b0;
      err_r    <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r <= next_state_s;
      busy_r  <= (next_state_s == RUN);
      done_r  <= (next_state_s == DONE);
      case (state_r)
        IDLE: begin
          if (start) begin
            a_r      <= a;
            b_r      <= b;
            op_r     <= op;
            carry_r  <= op;
            cnt_r    <= '0;
            result_r <= '0;
            cout_r   <= 1'b0;
            err_r    <= ~valid_s;
          end
        end
        RUN: begin
          for (int i = 0; i < DIGITS; i++) begin
            if (cnt_r == CW'(i)) begin
              result_r[4*i +: 4] <= digit_s;
            end
          end
          carry_r <= co_s;
          a_r     <= a_r >> 3'd4;
          b_r     <= b_r >> 3'd4;
          cnt_r   <= last_s ? '0 : cnt_r + CW'(1);
          if (last_s) begin
            cout_r <= op_r ? ~co_s : co_s;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy   = busy_r;
  assign done   = done_r;
  assign result = result_r;
  assign cout   = cout_r;
  assign err    = err_r;

endmodule

// File: tb/tb_bcd_serial_alu.sv
// Directed self-checking bench for bcd_serial_alu with DIGITS=4.
module tb_bcd_serial_alu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [15:0] a = 16'h0000;
  logic [15:0] b = 16'h0000;
  logic        busy, done, cout, err;
  logic [15:0] result;

  int checks = 0;
  int errors = 0;

  bcd_serial_alu #(.DIGITS(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .cout(cout), .err(err)
  );

  always #5 clk = ~clk;

  // Runs one operation; n counts rising edges after the accepting edge.
  task automatic do_op(input logic o, input logic [15:0] x, input logic [15:0] y,
                       input bit inject, output int lat, output int nbusy,
                       output int ndone, output int nboth, output logic [15:0] res,
                       output logic co, output logic er);
    lat = -1; nbusy = 0; ndone = 0; nboth = 0; res = 16'hxxxx; co = 1'bx; er = 1'bx;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    #1;
    start = 1'b0; a = 16'hFFFF; b = 16'hFFFF; op = ~o;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (busy) nbusy++;
      if (busy && done) nboth++;
      if (done) begin
        ndone++;
        if (lat < 0) begin
          lat = n; res = result; co = cout; er = err;
        end
      end
      if (inject && n == 1) begin
        start = 1'b1; op = 1'b0; a = 16'h1111; b = 16'h1111;
      end
      if (inject && n == 2) start = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, cout, err, result} !== 20'h0) begin
      errors++;
      $display("FAIL reset_outputs got busy=%b done=%b cout=%b err=%b result=%h expected all 0",
               busy, done, cout, err, result);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_arith(input string name, input logic o, input logic [15:0] x,
                            input logic [15:0] y, input logic [15:0] exp_res,
                            input logic exp_co);
    int lat, nb, nd, nbo;
    logic [15:0] res;
    logic co, er;
    do_op(o, x, y, 1'b0, lat, nb, nd, nbo, res, co, er);
    checks++; if (lat !== 4) begin errors++; $display("FAIL %s latency got %0d expected 4", name, lat); end
    checks++; if (res !== exp_res) begin errors++; $display("FAIL %s result got %h expected %h", name, res, exp_res); end
    checks++; if (co !== exp_co) begin errors++; $display("FAIL %s cout got %b expected %b", name, co, exp_co); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL %s err got %b expected 0", name, er); end
    checks++; if (nb !== 4) begin errors++; $display("FAIL %s busy_cycles got %0d expected 4", name, nb); end
    checks++; if (nd !== 1) begin errors++; $display("FAIL %s done_count got %0d expected 1", name, nd); end
    checks++; if (nbo !== 0) begin errors++; $display("FAIL %s busy_with_done got %0d expected 0", name, nbo); end
    checks++; if (result !== exp_res) begin errors++; $display("FAIL %s result_hold got %h expected %h", name, result, exp_res); end
  endtask

  task automatic test_invalid();
    int lat, nb, nd, nbo;
    logic [15:0] res;
    logic co, er;
    do_op(1'b0, 16'h12A4, 16'h0001, 1'b0, lat, nb, nd, nbo, res, co, er);
    checks++; if (lat !== 0) begin errors++; $display("FAIL invalid latency got %0d expected 0", lat); end
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL invalid err got %b expected 1", er); end
    checks++; if (res !== 16'h0000) begin errors++; $display("FAIL invalid result got %h expected 0000", res); end
    checks++; if (co !== 1'b0) begin errors++; $display("FAIL invalid cout got %b expected 0", co); end
    checks++; if (nb !== 0) begin errors++; $display("FAIL invalid busy_cycles got %0d expected 0", nb); end
    checks++; if (nd !== 1) begin errors++; $display("FAIL invalid done_count got %0d expected 1", nd); end
    test_arith("after_invalid", 1'b0, 16'h0001, 16'h0001, 16'h0002, 1'b0);
  endtask

  task automatic test_start_while_busy();
    int lat, nb, nd, nbo;
    logic [15:0] res;
    logic co, er;
    do_op(1'b0, 16'h0025, 16'h0017, 1'b1, lat, nb, nd, nbo, res, co, er);
    checks++; if (res !== 16'h0042) begin errors++; $display("FAIL busy_ignore result got %h expected 0042", res); end
    checks++; if (nd !== 1) begin errors++; $display("FAIL busy_ignore done_count got %0d expected 1", nd); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL busy_ignore latency got %0d expected 4", lat); end
    checks++; if (nb !== 4) begin errors++; $display("FAIL busy_ignore busy_cycles got %0d expected 4", nb); end
  endtask

  task automatic test_reset_mid_run();
    int nd;
    nd = 0;
    @(negedge clk);
    start = 1'b1; op = 1'b0; a = 16'h1234; b = 16'h8766;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, cout, err, result} !== 20'h0) begin
      errors++;
      $display("FAIL mid_reset outputs got busy=%b done=%b cout=%b err=%b result=%h expected all 0",
               busy, done, cout, err, result);
    end
    rst_n = 1'b1;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (done) nd++;
    end
    checks++; if (nd !== 0) begin errors++; $display("FAIL mid_reset spurious_done got %0d expected 0", nd); end
    test_arith("post_reset", 1'b0, 16'h9999, 16'h0001, 16'h0000, 1'b1);
  endtask

  task automatic test_back_to_back();
    int first, second, nd;
    first = -1; second = -1; nd = 0;
    @(negedge clk);
    start = 1'b1; op = 1'b0; a = 16'h0001; b = 16'h0002;
    @(posedge clk);
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (done) begin
        nd++;
        if (first < 0) first = n;
        else if (second < 0) second = n;
      end
      if (n == 11) start = 1'b0;
    end
    checks++; if (first !== 4) begin errors++; $display("FAIL b2b first_done got %0d expected 4", first); end
    checks++; if (second !== 10) begin errors++; $display("FAIL b2b second_done got %0d expected 10", second); end
    checks++; if (result !== 16'h0003) begin errors++; $display("FAIL b2b result got %h expected 0003", result); end
    repeat (8) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_arith("add_overflow", 1'b0, 16'h1234, 16'h8766, 16'h0000, 1'b1);
    test_arith("sub_simple",   1'b1, 16'h5000, 16'h1234, 16'h3766, 1'b0);
    test_arith("sub_borrow",   1'b1, 16'h0123, 16'h0456, 16'h9667, 1'b1);
    test_arith("add_plain",    1'b0, 16'h0358, 16'h0274, 16'h0632, 1'b0);
    test_invalid();
    test_start_while_busy();
    test_reset_mid_run();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_serial_alu.md
# bcd_serial_alu

Digit-serial BCD add/subtract controller. It sequences one shared single-digit BCD adder across a DIGITS-wide packed BCD operand pair, one digit per clock, least-significant digit first. It sits between a requester using a start/done handshake and the digit datapath, and owns operand latching, carry/borrow chaining, input validation and result assembly.

## Interface
Parameters:
- DIGITS, 4: number of BCD digits per operand (≥1); operand width is 4*DIGITS bits.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  request strobe; sampled only in IDLE.
- op  input  1  0 = add, 1 = subtract (a − b); sampled with start.
- a  input  4*DIGITS  packed BCD operand; digit i is a[4i+3:4i].
- b  input  4*DIGITS  packed BCD operand, same packing.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle completion pulse.
- result  output  4*DIGITS  packed BCD result; valid from done onward.
- cout  output  1  add: decimal carry out; sub: borrow (1 when a < b).
- err  output  1  1 when any digit of a or b exceeded 9 at start.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: when start=1, latch a, b and op into shift registers, clear result, set digit counter to 0, set chain carry = op.
  - If any latched digit > 9: set err=1, result=0, cout=0, go to DONE (no RUN cycles).
  - Otherwise clear err and go to RUN.
- RUN: each cycle, present digit x = a_k and y = (op ? 9 − b_k : b_k) with chain carry to the digit adder.
  - Write the sum digit into result digit k and the digit carry into the chain carry, then advance k.
  - After digit DIGITS−1, go to DONE.
- Digit arithmetic: s = x + y + c, 5-bit.
  - If s > 9: digit = s + 6 truncated to 4 bits, carry = 1.
  - Otherwise digit = s[3:0], carry = 0.
- Final flag:
  - Add: cout = final carry.
  - Sub: cout = ~final carry. Result is (a − b) mod 10^DIGITS, i.e. the ten's complement when a borrow occurs.
- DONE: done=1 for exactly one cycle, then unconditional return to IDLE.
- start outside IDLE is ignored; there is no queueing.
- result, cout and err hold their values until the next accepted start.

## Timing
- Reset (rst_n=0 at a rising edge): state=IDLE; busy=0, done=0, result=0, cout=0, err=0; counter and shift registers cleared. This applies mid-RUN as well. An aborted operation produces no done and no partial result.
- Normal latency: start accepted at edge E0. RUN occupies edges E1..EDIGITS. done is high in the cycle following EDIGITS, i.e. DIGITS cycles after acceptance. Throughput is one operation per DIGITS+2 cycles.
- Error latency: done is high in the cycle following E0.
- busy is high exactly DIGITS cycles per valid operation and is never high together with done.
- start held high continuously is accepted again in the IDLE cycle after DONE.
- Inputs a, b and op may change freely after acceptance.
- Counter wrap: the counter is ceil(log2(DIGITS)) bits wide (minimum 1) and never exceeds DIGITS−1.

## Structure
- Package bcd_pkg holds:
  - the state enum {IDLE, RUN, DONE};
  - the constants BCD_MAX=9 and BCD_ADJ=6;
  - a validity helper function (digit ≤ 9).
- Sub-module bcd_digit_add: combinational x[3:0], y[3:0], ci → s[3:0], co, implementing the digit arithmetic above. It is instantiated once and shared by all digits.
- The controller holds the FSM, counter, operand shift registers and result register.

## Test plan
All scenarios use DIGITS=4.
- Add with full overflow: op=0, a=0x1234, b=0x8766 → done at E0+4, result=0x0000, cout=1, err=0.
- Simple subtract: op=1, a=0x5000, b=0x1234 → result=0x3766, cout=0.
- Subtract with borrow: op=1, a=0x0123, b=0x0456 → result=0x9667, cout=1.
- Invalid digit: op=0, a=0x12A4, b=0x0001 → err=1, result=0, busy never high, done in the cycle after acceptance. A following valid 0x0001+0x0001 → result=0x0002, err=0.
- Start while busy is ignored: start a valid add, pulse start with different operands during RUN → only the first result appears, with exactly one done.
- Reset mid-operation: assert rst_n=0 on the second RUN cycle → next cycle shows all outputs 0 in IDLE, no done. A new start then completes normally with 0x9999+0x0001 → result=0x0000, cout=1.
